// File: rtl/axis_pkg.sv
// Shared encodings for the FIFO-to-AXI4-Stream framer: frame FSM states and skid depth.
// Holds no logic; imported by the framer and its skid buffer.
package axis_pkg;

    localparam int BUF_D = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OPEN = 1'b1
    } frame_st_t;

endpackage

// File: rtl/axis_skid_buf.sv
// 3-deep shift-register FIFO; entry 0 is the head and drives tdata straight from a flop.
// Zero-latency pop; push lands the clk after the FIFO read, and the caller never pushes when full.
module axis_skid_buf
    import axis_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              m_axis_aclk,
    input  logic              m_axis_aresetn,
    input  logic              push_vld,
    input  logic [DATA_W-1:0] push_dat,
    input  logic              pop_vld,
    output logic [DATA_W-1:0] head_dat,
    output logic [1:0]        cnt
);

    logic [DATA_W-1:0] mem_q [BUF_D];
    logic [DATA_W-1:0] mem_d [BUF_D];
    logic [1:0]        cnt_q;
    logic [1:0]        cnt_d;
    logic [1:0]        wr_idx;

    always_comb begin
        mem_d  = mem_q;
        wr_idx = cnt_q - {1'b0, pop_vld};
        if (pop_vld) begin
            for (int i = 0; i < BUF_D - 1; i++) begin
                mem_d[i] = mem_q[i+1];
            end
        end
        // A push in the same clk as a pop lands one slot lower.
        if (push_vld && (wr_idx < 2'(BUF_D))) begin
            mem_d[wr_idx] = push_dat;
        end
        cnt_d = cnt_q + {1'b0, push_vld} - {1'b0, pop_vld};
    end

    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            for (int i = 0; i < BUF_D; i++) begin
                mem_q[i] <= '0;
            end
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            cnt_q <= cnt_d;
        end
    end

    assign head_dat = mem_q[0];
    assign cnt      = cnt_q;

endmodule

// File: rtl/fifo_axis_framer.sv
// Drains a 1-cycle-latency FIFO into an AXI4-Stream master, framing beats by a runtime length.
// First word out after 2 clks (len 1) or 3 clks; tready low fills the 3-deep skid, then FIFO reads stop.
module fifo_axis_framer
    import axis_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16,
    parameter int TO_W   = 16
) (
    input  logic                m_axis_aclk,
    input  logic                m_axis_aresetn,
    input  logic                cfg_enable,
    input  logic [LEN_W-1:0]    cfg_frame_len,
    input  logic [TO_W-1:0]     cfg_timeout,
    input  logic                fifo_empty,
    input  logic [DATA_W-1:0]   fifo_rd_data,
    output logic                fifo_rd_en,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic [DATA_W-1:0]   m_axis_tdata,
    output logic [DATA_W/8-1:0] m_axis_tkeep,
    output logic                m_axis_tlast,
    output logic                m_axis_tuser,
    output logic [31:0]         stat_frames,
    output logic                stat_partial,
    output logic                busy
);

    frame_st_t         state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  beat_q, beat_d;
    logic [TO_W-1:0]   timer_q, timer_d;
    logic [31:0]       frames_q, frames_d;
    logic              partial_q, partial_d;
    logic              inflight_q, inflight_d;
    logic              tvalid_q, tvalid_d;
    logic              tlast_q, tlast_d;
    logic              tuser_q, tuser_d;

    logic              hs;
    logic [1:0]        cnt;
    logic [1:0]        cnt_nxt;
    logic [2:0]        occ_after_pop;
    logic [LEN_W-1:0]  cfg_len_eff;
    logic [LEN_W-1:0]  len_cur;
    logic [LEN_W-1:0]  len_nxt;
    logic              last_known;
    logic              idle_ok;
    logic              to_hit;

    assign hs            = tvalid_q & m_axis_tready;
    assign cfg_len_eff   = (cfg_frame_len == '0) ? LEN_W'(1) : cfg_frame_len;
    assign len_cur       = (state_q == ST_OPEN) ? len_q : cfg_len_eff;
    assign occ_after_pop = {1'b0, cnt} + {2'b0, inflight_q} - {2'b0, hs};
    assign fifo_rd_en    = cfg_enable & ~fifo_empty & (occ_after_pop < 3'(BUF_D));
    assign inflight_d    = fifo_rd_en;
    assign cnt_nxt       = cnt + {1'b0, inflight_q} - {1'b0, hs};

    axis_skid_buf #(
        .DATA_W (DATA_W)
    ) u_skid (
        .m_axis_aclk    (m_axis_aclk),
        .m_axis_aresetn (m_axis_aresetn),
        .push_vld       (inflight_q),
        .push_dat       (fifo_rd_data),
        .pop_vld        (hs),
        .head_dat       (m_axis_tdata),
        .cnt            (cnt)
    );

    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        beat_d  = beat_q;
        if (hs) begin
            if (tlast_q) begin
                state_d = ST_IDLE;
                beat_d  = '0;
            end else begin
                state_d = ST_OPEN;
                beat_d  = beat_q + LEN_W'(1);
                if (state_q == ST_IDLE) begin
                    len_d = cfg_len_eff;
                end
            end
        end
    end

    always_comb begin
        len_nxt    = (state_d == ST_OPEN) ? len_d : cfg_len_eff;
        last_known = (beat_d == len_nxt - LEN_W'(1));
        // Only a lone held-back head (or nothing) counts as idle; any arrival or handshake restarts it.
        idle_ok    = (state_q == ST_OPEN) & (cnt <= 2'd1) & ~inflight_q & ~hs;
        timer_d    = '0;
        if (idle_ok) begin
            timer_d = (timer_q == '1) ? timer_q : timer_q + TO_W'(1);
        end
        to_hit     = (cfg_timeout != '0) & (timer_d >= cfg_timeout);

        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        tuser_d  = tuser_q;
        if (!tvalid_q || m_axis_tready) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            tuser_d  = 1'b0;
            if (cnt_nxt >= 2'd2) begin
                tvalid_d = 1'b1;
                tlast_d  = last_known;
            end else if ((cnt_nxt == 2'd1) && (last_known || to_hit || !cfg_enable)) begin
                tvalid_d = 1'b1;
                tlast_d  = 1'b1;
            end
            tuser_d = tvalid_d & (state_d == ST_IDLE);
        end

        frames_d  = frames_q + {31'd0, hs & tlast_q};
        partial_d = hs & tlast_q & ((beat_q + LEN_W'(1)) < len_cur);
    end

    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            timer_q    <= '0;
            frames_q   <= '0;
            partial_q  <= 1'b0;
            inflight_q <= 1'b0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            tuser_q    <= 1'b0;
        end else begin
            timer_q    <= timer_d;
            frames_q   <= frames_d;
            partial_q  <= partial_d;
            inflight_q <= inflight_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
            tuser_q    <= tuser_d;
        end
    end

    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tuser  = tuser_q;
    assign m_axis_tkeep  = '1;
    assign stat_frames   = frames_q;
    assign stat_partial  = partial_q;
    assign busy          = (state_q == ST_OPEN) | (cnt != 2'd0) | inflight_q;

endmodule

// File: tb/tb_fifo_axis_framer.sv
// Directed bench for fifo_axis_framer: table of framing vectors plus hand sequences for
// latency, timeout, mid-frame length change, disable/re-enable and async reset.
module tb_fifo_axis_framer;

    localparam int DATA_W = 32;
    localparam int LEN_W  = 16;
    localparam int TO_W   = 16;

    logic              clk = 1'b0;
    logic              rstn;
    logic              cfg_enable;
    logic [LEN_W-1:0]  cfg_frame_len;
    logic [TO_W-1:0]   cfg_timeout;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_rd_data;
    logic              fifo_rd_en;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic [DATA_W-1:0] m_axis_tdata;
    logic [3:0]        m_axis_tkeep;
    logic              m_axis_tlast;
    logic              m_axis_tuser;
    logic [31:0]       stat_frames;
    logic              stat_partial;
    logic              busy;

    always #5 clk = ~clk;

    fifo_axis_framer #(.DATA_W(DATA_W), .LEN_W(LEN_W), .TO_W(TO_W)) dut (
        .m_axis_aclk    (clk),
        .m_axis_aresetn (rstn),
        .cfg_enable     (cfg_enable),
        .cfg_frame_len  (cfg_frame_len),
        .cfg_timeout    (cfg_timeout),
        .fifo_empty     (fifo_empty),
        .fifo_rd_data   (fifo_rd_data),
        .fifo_rd_en     (fifo_rd_en),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tkeep   (m_axis_tkeep),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tuser   (m_axis_tuser),
        .stat_frames    (stat_frames),
        .stat_partial   (stat_partial),
        .busy           (busy)
    );

    // Source FIFO model: 1-cycle read latency.
    logic [31:0] fmem [256];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_rd_data <= fmem[rd_ptr[7:0]];
            rd_ptr       <= rd_ptr + 1;
        end
    end

    // Beat log and stall-stability watcher, sampled on the falling edge.
    logic [31:0] lg_dat [512];
    logic        lg_last [512];
    logic        lg_user [512];
    int          lg_cyc [512];
    int          lg_n = 0;
    int          cyc = 0;
    int          partial_n = 0;
    int          stall_err = 0;
    logic        hold_pend = 1'b0;
    logic [31:0] hold_dat;
    logic        hold_last, hold_user;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rstn && m_axis_tvalid && m_axis_tready) begin
            lg_dat[lg_n]  <= m_axis_tdata;
            lg_last[lg_n] <= m_axis_tlast;
            lg_user[lg_n] <= m_axis_tuser;
            lg_cyc[lg_n]  <= cyc;
            lg_n          <= lg_n + 1;
        end
        if (rstn && stat_partial) partial_n <= partial_n + 1;
        if (!rstn) begin
            hold_pend <= 1'b0;
        end else begin
            if (hold_pend && !(m_axis_tvalid && m_axis_tdata == hold_dat &&
                               m_axis_tlast == hold_last && m_axis_tuser == hold_user))
                stall_err <= stall_err + 1;
            hold_pend <= m_axis_tvalid && !m_axis_tready;
            hold_dat  <= m_axis_tdata;
            hold_last <= m_axis_tlast;
            hold_user <= m_axis_tuser;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_words(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            fmem[wr_ptr[7:0]] = base + 32'(i);
            wr_ptr++;
        end
    endtask

    task automatic run_until(input int target, input int budget, input bit toggle);
        int k;
        k = 0;
        while ((lg_n < target) && (k < budget)) begin
            if (toggle) m_axis_tready = ~m_axis_tready;
            tick(1);
            k++;
        end
        m_axis_tready = 1'b1;
        check("beats_within_budget", 64'(lg_n >= target), 64'd1);
    endtask

    task automatic measure_latency(output int lat);
        int rd_at, vld_at;
        rd_at  = -1;
        vld_at = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (fifo_rd_en && rd_at < 0) rd_at = k;
            if (m_axis_tvalid && vld_at < 0) vld_at = k;
        end
        lat = (rd_at < 0 || vld_at < 0) ? -1 : vld_at - rd_at;
        tick(1);
    endtask

    typedef struct {
        int len;
        int nwords;
        bit toggle;
        int exp_frames;
    } vec_t;

    vec_t vt [5];

    initial begin
        int base_n, base_rd, base_p, eff, lat, k;
        logic [31:0] base_fr, wbase;

        vt[0] = '{8, 16, 1'b0, 2};
        vt[1] = '{4,  4, 1'b1, 1};
        vt[2] = '{0,  5, 1'b0, 5};
        vt[3] = '{1,  3, 1'b1, 3};
        vt[4] = '{3,  6, 1'b1, 2};

        rstn = 1'b0; cfg_enable = 1'b0; cfg_frame_len = 16'd8; cfg_timeout = '0;
        m_axis_tready = 1'b1;
        tick(3);
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tdata", m_axis_tdata, 0);
        check("rst_stat_frames", stat_frames, 0);
        check("rst_busy", busy, 0);
        rstn = 1'b1;
        tick(2);

        for (int v = 0; v < 5; v++) begin
            base_n = lg_n; base_rd = rd_ptr; base_fr = stat_frames;
            wbase  = 32'(v) << 8;
            cfg_frame_len = 16'(vt[v].len);
            cfg_enable    = 1'b1;
            push_words(vt[v].nwords, wbase);
            run_until(base_n + vt[v].nwords, 400, vt[v].toggle);
            tick(10);
            eff = (vt[v].len == 0) ? 1 : vt[v].len;
            check("vec_beat_count", 64'(lg_n - base_n), 64'(vt[v].nwords));
            for (int i = 0; i < vt[v].nwords; i++) begin
                check("vec_tdata", lg_dat[base_n+i], wbase + 32'(i));
                check("vec_tuser", lg_user[base_n+i], 64'((i % eff) == 0));
                check("vec_tlast", lg_last[base_n+i], 64'((i % eff) == eff - 1));
            end
            check("vec_frames", stat_frames - base_fr, 64'(vt[v].exp_frames));
            check("vec_fifo_reads", 64'(rd_ptr - base_rd), 64'(vt[v].nwords));
            check("vec_busy_idle", busy, 0);
            if (!vt[v].toggle)
                check("vec_throughput", 64'(lg_cyc[base_n+vt[v].nwords-1] - lg_cyc[base_n]),
                      64'(vt[v].nwords - 1));
        end

        // First-word latency: 2 clks for length 1, 3 when held back for the next word.
        cfg_frame_len = 16'd1;
        push_words(1, 32'h1000);
        measure_latency(lat);
        check("latency_len1", 64'(lat), 64'd2);
        cfg_frame_len = 16'd2;
        base_n = lg_n;
        push_words(2, 32'h1100);
        measure_latency(lat);
        tick(5);
        check("latency_len2", 64'(lat), 64'd3);
        check("latency_len2_last", lg_last[base_n+1], 1);

        // Idle timeout closes a partial frame on the held-back word.
        base_n = lg_n; base_fr = stat_frames; base_p = partial_n;
        cfg_frame_len = 16'd8; cfg_timeout = 16'd20;
        push_words(5, 32'h2000);
        run_until(base_n + 5, 200, 1'b0);
        tick(5);
        check("to_beat_count", 64'(lg_n - base_n), 64'd5);
        check("to_tuser_first", lg_user[base_n], 1);
        for (int i = 0; i < 4; i++) check("to_tlast_early", lg_last[base_n+i], 0);
        check("to_tlast_word4", lg_last[base_n+4], 1);
        check("to_tdata_word4", lg_dat[base_n+4], 32'h2004);
        check("to_idle_gap", 64'(lg_cyc[base_n+4] - lg_cyc[base_n+3]), 64'd21);
        check("to_partial", 64'(partial_n - base_p), 64'd1);
        check("to_frames", stat_frames - base_fr, 64'd1);
        cfg_timeout = '0;

        // Length changed mid-frame only applies to the next frame.
        base_n = lg_n; base_fr = stat_frames;
        cfg_frame_len = 16'd8;
        push_words(11, 32'h3000);
        k = 0;
        while (lg_n < base_n + 1 && k < 50) begin tick(1); k++; end
        cfg_frame_len = 16'd3;
        run_until(base_n + 11, 300, 1'b0);
        tick(10);
        for (int i = 0; i < 11; i++) begin
            check("lenchg_tlast", lg_last[base_n+i], 64'(i == 7 || i == 10));
            check("lenchg_tuser", lg_user[base_n+i], 64'(i == 0 || i == 8));
        end
        check("lenchg_frames", stat_frames - base_fr, 64'd2);

        // Disable after 6 of 10 words, then re-enable.
        base_n = lg_n; base_fr = stat_frames; base_p = partial_n; base_rd = rd_ptr;
        cfg_frame_len = 16'd10;
        push_words(10, 32'h4000);
        k = 0;
        while ((rd_ptr - base_rd) < 6 && k < 100) begin tick(1); k++; end
        cfg_enable = 1'b0;
        tick(30);
        check("dis_beat_count", 64'(lg_n - base_n), 64'd6);
        check("dis_fifo_reads", 64'(rd_ptr - base_rd), 64'd6);
        for (int i = 0; i < 6; i++) begin
            check("dis_tdata", lg_dat[base_n+i], 32'h4000 + 32'(i));
            check("dis_tlast", lg_last[base_n+i], 64'(i == 5));
        end
        check("dis_partial", 64'(partial_n - base_p), 64'd1);
        check("dis_frames", stat_frames - base_fr, 64'd1);
        check("dis_busy", busy, 0);
        cfg_enable = 1'b1;
        base_n = lg_n;
        run_until(base_n + 3, 100, 1'b0);
        tick(10);
        check("reen_beats", 64'(lg_n - base_n), 64'd3);
        check("reen_tuser", lg_user[base_n], 1);
        check("reen_tdata", lg_dat[base_n], 32'h4006);
        check("reen_busy_open", busy, 1);
        cfg_enable = 1'b0;
        tick(10);
        check("reen_close_beats", 64'(lg_n - base_n), 64'd4);
        check("reen_close_tlast", lg_last[base_n+3], 1);
        check("reen_close_tdata", lg_dat[base_n+3], 32'h4009);
        cfg_enable = 1'b1;

        // Async reset mid-frame with words buffered and tvalid high.
        base_n = lg_n;
        cfg_frame_len = 16'd8;
        m_axis_tready = 1'b0;
        push_words(4, 32'h5000);
        tick(8);
        m_axis_tready = 1'b1;
        tick(1);
        m_axis_tready = 1'b0;
        tick(4);
        check("pre_rst_beats", 64'(lg_n - base_n), 64'd1);
        check("pre_rst_tvalid", m_axis_tvalid, 1);
        check("pre_rst_tkeep", m_axis_tkeep, 4'hF);
        #2;
        rstn = 1'b0;
        #1;
        check("arst_tvalid", m_axis_tvalid, 0);
        check("arst_tlast", m_axis_tlast, 0);
        check("arst_tuser", m_axis_tuser, 0);
        check("arst_tdata", m_axis_tdata, 0);
        check("arst_frames", stat_frames, 0);
        check("arst_busy", busy, 0);
        tick(2);
        rstn = 1'b1;
        m_axis_tready = 1'b1;
        cfg_frame_len = 16'd2;
        base_n = lg_n;
        push_words(2, 32'h6000);
        run_until(base_n + 2, 50, 1'b0);
        tick(5);
        check("post_rst_tuser", lg_user[base_n], 1);
        check("post_rst_tdata", lg_dat[base_n], 32'h6000);
        check("post_rst_tlast", lg_last[base_n+1], 1);
        check("post_rst_frames", stat_frames, 1);

        check("stall_stable_violations", 64'(stall_err), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule
